// File: rtl/hdlc_fcs_checker_pkg.sv
// Shared definitions for the HDLC FCS path: CCITT constants, checker FSM
// encoding and the byte-wide CRC update used by both framer and checker.
package hdlc_fcs_checker_pkg;

   localparam logic [15:0] CRC_POLY    = 16'h1021;
   localparam logic [15:0] CRC_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC_RESIDUE = 16'h0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL1  = 2'd1,
      FILL2  = 2'd2,
      STREAM = 2'd3
   } fcs_state_t;

   // MSB-first CCITT update of the running CRC with one byte; no
   // reflection and no final XOR, so a frame followed by its own FCS
   // leaves a zero remainder.
   function automatic logic [15:0] crc16_ccitt_update(input logic [15:0] crc,
                                                      input logic [7:0]  data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/hdlc_fcs_checker_crc16_ccitt_byte.sv
// CRC register with byte-wide update; crc_next shows the value after
// folding in the current byte so the caller can judge the frame in the
// same cycle its last byte arrives.
module crc16_ccitt_byte
   import hdlc_fcs_checker_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [7:0]  data,
   output logic [15:0] crc_next
);

   logic [15:0] crc;

   // A load restarts from the init value and still consumes this byte
   assign crc_next = crc16_ccitt_update(load ? CRC_INIT : crc, data);

   // Hold the running CRC, advancing once per accepted byte
   always_ff @(posedge clk) begin
      if (!rst) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/hdlc_fcs_checker.sv
// Receive-side FCS checker: strips the two trailing FCS bytes through a
// two-byte delay line, forwards the payload and reports frame status.
module hdlc_fcs_checker
   import hdlc_fcs_checker_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_sop,
   input  logic        in_eop,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sop,
   output logic        out_eop,
   output logic        crc_ok,
   output logic        crc_err,
   output logic        abort,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   fcs_state_t  state;
   logic [7:0]  d0;
   logic [7:0]  d1;
   logic [15:0] crc_next;
   logic        fwd;
   logic        ok_ev;
   logic        err_ev;
   logic        abort_ev;
   logic [16:0] bad_sum;

   crc16_ccitt_byte u_crc (
      .clk      (clk),
      .rst      (rst),
      .en       (in_valid),
      .load     (in_sop),
      .data     (in_data),
      .crc_next (crc_next)
   );

   // Decide what the current byte does: forward the oldest held byte,
   // end a frame with a verdict, flag a runt, or cut a frame short
   always_comb begin
      fwd      = 1'b0;
      ok_ev    = 1'b0;
      err_ev   = 1'b0;
      abort_ev = 1'b0;
      if (in_valid) begin
         if (in_sop) begin
            abort_ev = (state != IDLE);
            err_ev   = in_eop;
         end else begin
            case (state)
               FILL1: err_ev = in_eop;
               FILL2: begin
                  err_ev = in_eop;
                  fwd    = !in_eop;
               end
               STREAM: begin
                  fwd = 1'b1;
                  if (in_eop) begin
                     ok_ev  = (crc_next == CRC_RESIDUE);
                     err_ev = (crc_next != CRC_RESIDUE);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Frame FSM, delay line and registered output strobes
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         d0        <= 8'h00;
         d1        <= 8'h00;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         crc_ok    <= 1'b0;
         crc_err   <= 1'b0;
         abort     <= 1'b0;
      end else begin
         out_valid <= fwd;
         out_sop   <= fwd && (state == FILL2);
         out_eop   <= fwd && in_eop;
         crc_ok    <= ok_ev;
         crc_err   <= err_ev;
         abort     <= abort_ev;
         if (fwd) begin
            out_data <= d1;
         end
         if (in_valid) begin
            if (in_sop) begin
               d0    <= in_data;
               d1    <= 8'h00;
               state <= in_eop ? IDLE : FILL1;
            end else if (state != IDLE) begin
               d1 <= d0;
               d0 <= in_data;
               if (in_eop) begin
                  state <= IDLE;
               end else if (state == FILL1) begin
                  state <= FILL2;
               end else begin
                  state <= STREAM;
               end
            end
         end
      end
   end

   // Abort and error can coincide when a runt cuts a frame, so the bad
   // counter may need to advance by two in one cycle
   always_comb begin
      bad_sum = {1'b0, bad_cnt} + {15'd0, abort_ev} + {15'd0, err_ev};
   end

   // Saturating good/bad frame counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         good_cnt <= 16'h0000;
         bad_cnt  <= 16'h0000;
      end else begin
         if (ok_ev && (good_cnt != 16'hFFFF)) begin
            good_cnt <= good_cnt + 16'd1;
         end
         bad_cnt <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
      end
   end

endmodule

// File: tb/tb_hdlc_fcs_checker.sv
// Scoreboard bench for hdlc_fcs_checker: frames are modelled whole, their
// expected outputs queued up front, and a negedge monitor drains the queue.
module tb_hdlc_fcs_checker;

   typedef struct {
      int         kind;
      logic [7:0] data;
      bit         sop;
      bit         eop;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_sop;
   logic        in_eop;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        out_eop;
   logic        crc_ok;
   logic        crc_err;
   logic        abort;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   exp_good    = 0;
   int   exp_bad     = 0;

   hdlc_fcs_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .crc_ok    (crc_ok),
      .crc_err   (crc_err),
      .abort     (abort),
      .good_cnt  (good_cnt),
      .bad_cnt   (bad_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check steps the counters here
   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Bit-serial CCITT remainder of a byte string, init FFFF
   function automatic logic [15:0] fcsOf(input logic [7:0] bytes[$]);
      logic [15:0] c;
      logic [7:0]  d;
      logic        fb;
      c = 16'hFFFF;
      foreach (bytes[i]) begin
         d = bytes[i];
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ d[b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   task automatic pushData(input logic [7:0] d, input bit s, input bit e);
      exp_t x;
      x.kind = 0; x.data = d; x.sop = s; x.eop = e;
      sb.push_back(x);
   endtask

   task automatic pushPulse(input int kind, input bit with_eop);
      exp_t x;
      x.kind = kind; x.data = 8'h00; x.sop = 1'b0; x.eop = with_eop;
      sb.push_back(x);
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit s, input bit e);
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_data  = 8'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gapBefore(input int mode, input int idx);
      if (mode == 1 && idx > 0) idleCycles(1);
      else if (mode == 2) idleCycles($urandom_range(0, 2));
   endtask

   // Complete frame: payload plus its FCS, optionally with the last bit flipped
   task automatic sendFrame(input logic [7:0] payload[$], input bit corrupt, input int mode);
      logic [7:0]  frame[$];
      logic [15:0] f;
      int          n;
      f     = fcsOf(payload);
      frame = payload;
      frame.push_back(f[15:8]);
      frame.push_back(f[7:0]);
      n = frame.size();
      if (corrupt) frame[n-1] = frame[n-1] ^ 8'h01;
      foreach (payload[i]) pushData(payload[i], i == 0, i == payload.size() - 1);
      pushPulse(corrupt ? 2 : 1, 1'b1);
      if (corrupt) exp_bad++; else exp_good++;
      for (int i = 0; i < n; i++) begin
         gapBefore(mode, i);
         applyStimulus(frame[i], i == 0, i == n - 1);
      end
   endtask

   // Runt of one or two bytes: no payload out, just an error
   task automatic sendRunt(input int n, input int mode);
      pushPulse(2, 1'b0);
      exp_bad++;
      for (int i = 0; i < n; i++) begin
         gapBefore(mode, i);
         applyStimulus(8'($urandom), i == 0, i == n - 1);
      end
   endtask

   // First k bytes of a frame with no end; bytes older than two are forwarded
   task automatic sendPartial(input int k, input bit expect_abort, input int mode);
      logic [7:0] b[$];
      for (int i = 0; i < k; i++) b.push_back(8'($urandom));
      for (int i = 0; i < k - 2; i++) pushData(b[i], i == 0, 1'b0);
      if (expect_abort) begin
         pushPulse(3, 1'b0);
         exp_bad++;
      end
      for (int i = 0; i < k; i++) begin
         gapBefore(mode, i);
         applyStimulus(b[i], i == 0, 1'b0);
      end
   endtask

   task automatic randomPayload(input int len, output logic [7:0] p[$]);
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
   endtask

   task automatic checkCounters(input string tag);
      compare({tag, "_good_cnt"}, {16'd0, good_cnt}, exp_good);
      compare({tag, "_bad_cnt"},  {16'd0, bad_cnt},  exp_bad);
   endtask

   task automatic checkQuiet(input string tag);
      compare({tag, "_out_valid"}, {31'd0, out_valid}, 0);
      compare({tag, "_pulses"},    {29'd0, crc_ok, crc_err, abort}, 0);
      compare({tag, "_out_data"},  {24'd0, out_data}, 0);
      compare({tag, "_sop_eop"},   {30'd0, out_sop, out_eop}, 0);
   endtask

   // Monitor: every output beat or status pulse must match the queue head
   task automatic checkOutput();
      exp_t x;
      if (out_valid) begin
         if (sb.size() == 0) begin
            compare("unexpected_out_valid", {23'd0, out_sop, out_eop, out_data}, 32'hFFFF_FFFF);
         end else begin
            x = sb.pop_front();
            compare("out_kind", 0, x.kind);
            compare("out_beat", {22'd0, out_sop, out_eop, out_data}, {22'd0, x.sop, x.eop, x.data});
         end
      end
      if (crc_ok || crc_err || abort) begin
         if (sb.size() == 0) begin
            compare("unexpected_pulse", {29'd0, abort, crc_err, crc_ok}, 32'hFFFF_FFFF);
         end else begin
            x = sb.pop_front();
            compare("pulse_kind", {29'd0, abort, crc_err, crc_ok},
                    (x.kind >= 1) ? (32'd1 << (x.kind - 1)) : 32'hFFFF_FFFF);
            compare("pulse_with_eop", {31'd0, out_eop}, {31'd0, x.eop});
         end
      end
   endtask

   always @(negedge clk) checkOutput();

   initial begin
      logic [7:0] p[$];
      int         choice;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkQuiet("reset");
      checkCounters("reset");
      rst = 1'b1;

      p = '{8'h01, 8'h02, 8'h03};
      sendFrame(p, 1'b0, 0);
      idleCycles(4);
      checkCounters("good_frame");

      sendFrame(p, 1'b1, 0);
      idleCycles(4);
      checkCounters("bad_fcs");

      p = '{8'hAA, 8'hBB};
      pushPulse(2, 1'b0);
      exp_bad++;
      applyStimulus(p[0], 1'b1, 1'b0);
      applyStimulus(p[1], 1'b0, 1'b1);
      idleCycles(4);
      checkCounters("runt2");

      sendRunt(1, 0);
      idleCycles(4);
      checkCounters("runt1");

      sendPartial(4, 1'b1, 0);
      randomPayload(6, p);
      sendFrame(p, 1'b0, 0);
      idleCycles(4);
      checkCounters("abort");

      randomPayload(7, p);
      sendFrame(p, 1'b0, 1);
      idleCycles(4);
      checkCounters("gapped");

      sendPartial(5, 1'b0, 0);
      idleCycles(2);
      rst = 1'b0;
      idleCycles(2);
      checkQuiet("mid_reset");
      compare("mid_reset_counters", {good_cnt, bad_cnt}, 0);
      compare("mid_reset_queue", sb.size(), 0);
      exp_good = 0;
      exp_bad  = 0;
      rst = 1'b1;
      randomPayload(4, p);
      sendFrame(p, 1'b0, 0);
      idleCycles(4);
      checkCounters("after_reset");

      for (int it = 0; it < 60; it++) begin
         choice = $urandom_range(0, 9);
         if (choice <= 4) begin
            randomPayload($urandom_range(2, 12), p);
            sendFrame(p, choice == 4, 2);
         end else if (choice == 5) begin
            sendRunt($urandom_range(1, 2), 2);
         end else if (choice == 6) begin
            sendPartial($urandom_range(1, 8), 1'b1, 2);
            randomPayload($urandom_range(2, 10), p);
            sendFrame(p, 1'b0, 2);
         end else begin
            applyStimulus(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
         end
         if (choice == 9) idleCycles($urandom_range(0, 3));
      end
      idleCycles(6);
      checkCounters("random");
      compare("queue_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
